// File: rtl/hdmi_data_decoder.sv
// HDMI data-island packet decoder: rebuilds 32-slot packets from TERC4-decoded nibbles,
// checks the BCH header/subpacket ECC, and extracts ACR CTS/N and L/R audio samples.
module hdmi_data_decoder (
    input  logic         i_pixclk,
    input  logic         i_reset_n,
    input  logic         i_data,
    input  logic [3:0]   i_d0,
    input  logic [3:0]   i_d1,
    input  logic [3:0]   i_d2,
    output logic         o_pkt_valid,
    output logic [23:0]  o_pkt_hdr,
    output logic [223:0] o_pkt_sub,
    output logic         o_hdr_err,
    output logic [3:0]   o_sub_err,
    output logic         o_sync_err,
    output logic         o_acr_valid,
    output logic [19:0]  o_cts,
    output logic [19:0]  o_n,
    output logic         o_audio_valid,
    output logic [15:0]  o_audio_l,
    output logic [15:0]  o_audio_r,
    output logic         o_audio_b,
    output logic         o_audio_par_err
);

    localparam logic [7:0] BCH_POLY   = 8'hC1;
    localparam logic [7:0] TYPE_ACR   = 8'h01;
    localparam logic [7:0] TYPE_AUDIO = 8'h02;

    typedef enum logic {IDLE, RECV} state_t;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        b;
        logic        par_err;
    } sample_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? BCH_POLY : 8'h00);
    endfunction

    // Returns {err, lfsr}: data slots advance the LFSR, parity slots compare and shift out.
    function automatic logic [8:0] hdr_step(input logic [7:0] c, input logic bad,
                                            input logic par, input logic b);
        if (!par)
            return {bad, lfsr_step(c, b)};
        return {bad | (b != c[7]), c[6:0], 1'b0};
    endfunction

    function automatic logic [8:0] sub_step(input logic [7:0] c, input logic bad,
                                            input logic par, input logic e, input logic o);
        if (!par)
            return {bad, lfsr_step(lfsr_step(c, e), o)};
        return {bad | (e != c[7]) | (o != c[6]), c[5:0], 2'b00};
    endfunction

    // hsync/vsync ride on ch0 but carry nothing for packet decoding.
    logic unused_sync;
    assign unused_sync = ^i_d0[1:0];

    state_t      state, state_n;
    logic [4:0]  offset, offset_n, slot;
    logic        capture, sync_err_n, pkt_done;
    logic        first_slot, hdr_par_slot, sub_par_slot;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        offset_n   = offset;
        slot       = offset;
        capture    = 1'b0;
        sync_err_n = 1'b0;
        case (state)
            IDLE: begin
                if (i_data && !i_d0[3]) begin
                    capture  = 1'b1;
                    slot     = 5'd0;
                    state_n  = RECV;
                    offset_n = 5'd1;
                end
            end
            RECV: begin
                if (!i_data) begin
                    state_n    = IDLE;
                    offset_n   = 5'd0;
                    sync_err_n = (offset != 5'd0);
                end else begin
                    capture = 1'b1;
                    if (!i_d0[3] && offset != 5'd0) begin
                        sync_err_n = 1'b1;
                        slot       = 5'd0;
                    end
                    offset_n = slot + 5'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign first_slot   = (slot == 5'd0);
    assign hdr_par_slot = (slot >= 5'd24);
    assign sub_par_slot = (slot >= 5'd28);
    assign pkt_done     = capture && (slot == 5'd31);

    logic [7:0]  hdr_crc;
    logic        hdr_bad;
    logic [8:0]  hdr_next;
    logic [23:0] hdr_data;

    assign hdr_next = hdr_step(first_slot ? 8'h00 : hdr_crc, first_slot ? 1'b0 : hdr_bad,
                               hdr_par_slot, i_d0[2]);

    // NOTE: state and checkers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            offset  <= 5'd0;
            hdr_crc <= 8'h00;
            hdr_bad <= 1'b0;
        end else begin
            state  <= state_n;
            offset <= offset_n;
            if (capture)
                {hdr_bad, hdr_crc} <= hdr_next;
        end
    end

    // NOTE: payload storage has no reset; every bit is rewritten before a packet can complete.
    always_ff @(posedge i_pixclk) begin
        if (capture && !hdr_par_slot)
            hdr_data <= {i_d0[2], hdr_data[23:1]};
    end

    logic [223:0]      sub_data;
    logic [3:0]        sub_bad_n;
    sample_t [3:0]     sample_in;

    for (genvar k = 0; k < 4; k++) begin : g_sub
        logic [7:0]  crc;
        logic        bad;
        logic [8:0]  next;
        logic [55:0] data;
        logic        par_err;

        assign next = sub_step(first_slot ? 8'h00 : crc, first_slot ? 1'b0 : bad,
                               sub_par_slot, i_d1[k], i_d2[k]);

        always_ff @(posedge i_pixclk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                crc <= 8'h00;
                bad <= 1'b0;
            end else if (capture) begin
                {bad, crc} <= next;
            end
        end

        always_ff @(posedge i_pixclk) begin
            if (capture && !sub_par_slot)
                data <= {i_d2[k], i_d1[k], data[55:2]};
        end

        assign par_err = (data[51] != ^{data[23:0], data[50:48]}) |
                         (data[55] != ^{data[47:24], data[54:52]});

        assign sub_bad_n[k]         = next[8];
        assign sub_data[56*k +: 56] = data;
        assign sample_in[k]         = {data[23:8], data[47:32], hdr_data[20+k], par_err};
    end

    logic        acr_ok;
    logic [3:0]  aud_mask;
    logic [55:0] sub0;

    assign sub0     = sub_data[55:0];
    assign acr_ok   = (hdr_data[7:0] == TYPE_ACR) && !hdr_next[8] && !sub_bad_n[0];
    assign aud_mask = (hdr_data[7:0] == TYPE_AUDIO && !hdr_next[8]) ?
                      (hdr_data[11:8] & ~sub_bad_n) : 4'b0000;

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_pkt_valid <= 1'b0;
            o_pkt_hdr   <= 24'h0;
            o_pkt_sub   <= 224'h0;
            o_hdr_err   <= 1'b0;
            o_sub_err   <= 4'h0;
            o_sync_err  <= 1'b0;
            o_acr_valid <= 1'b0;
            o_cts       <= 20'h0;
            o_n         <= 20'h0;
        end else begin
            o_pkt_valid <= pkt_done;
            o_sync_err  <= sync_err_n;
            o_acr_valid <= pkt_done && acr_ok;
            if (pkt_done) begin
                o_pkt_hdr <= hdr_data;
                o_pkt_sub <= sub_data;
                o_hdr_err <= hdr_next[8];
                o_sub_err <= sub_bad_n;
            end
            if (pkt_done && acr_ok) begin
                o_cts <= {sub0[11:8], sub0[23:16], sub0[31:24]};
                o_n   <= {sub0[35:32], sub0[47:40], sub0[55:48]};
            end
        end
    end

    // Sample buffer: loaded when a packet completes, drained lowest subpacket first.
    sample_t [3:0] buf_q;
    logic [3:0]    pend;
    logic [3:0]    pend_clr;
    logic [1:0]    sel;

    always_comb begin
        sel = 2'd0;
        casez (pend)
            4'b???1: sel = 2'd0;
            4'b??10: sel = 2'd1;
            4'b?100: sel = 2'd2;
            4'b1000: sel = 2'd3;
            default: sel = 2'd0;
        endcase
        pend_clr = 4'b0001 << sel;
    end

    always_ff @(posedge i_pixclk) begin
        if (pkt_done)
            buf_q <= sample_in;
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pend            <= 4'h0;
            o_audio_valid   <= 1'b0;
            o_audio_l       <= 16'h0;
            o_audio_r       <= 16'h0;
            o_audio_b       <= 1'b0;
            o_audio_par_err <= 1'b0;
        end else begin
            if (pkt_done)
                pend <= aud_mask;
            else
                pend <= pend & ~pend_clr;
            o_audio_valid <= |pend;
            if (|pend)
                {o_audio_l, o_audio_r, o_audio_b, o_audio_par_err} <= buf_q[sel];
        end
    end

endmodule

// File: tb/tb_hdmi_data_decoder.sv
// Self-checking bench for hdmi_data_decoder: a packet-level model predicts every
// output per cycle; directed packets plus literal expectations pin the model.
module tb_hdmi_data_decoder;

    logic         i_pixclk = 1'b0;
    logic         i_reset_n = 1'b0;
    logic         i_data = 1'b0;
    logic [3:0]   i_d0 = 4'h8, i_d1 = 4'h0, i_d2 = 4'h0;
    logic         o_pkt_valid, o_hdr_err, o_sync_err, o_acr_valid;
    logic [23:0]  o_pkt_hdr;
    logic [223:0] o_pkt_sub;
    logic [3:0]   o_sub_err;
    logic [19:0]  o_cts, o_n;
    logic         o_audio_valid, o_audio_b, o_audio_par_err;
    logic [15:0]  o_audio_l, o_audio_r;

    hdmi_data_decoder dut (
        .i_pixclk(i_pixclk), .i_reset_n(i_reset_n), .i_data(i_data),
        .i_d0(i_d0), .i_d1(i_d1), .i_d2(i_d2),
        .o_pkt_valid(o_pkt_valid), .o_pkt_hdr(o_pkt_hdr), .o_pkt_sub(o_pkt_sub),
        .o_hdr_err(o_hdr_err), .o_sub_err(o_sub_err), .o_sync_err(o_sync_err),
        .o_acr_valid(o_acr_valid), .o_cts(o_cts), .o_n(o_n),
        .o_audio_valid(o_audio_valid), .o_audio_l(o_audio_l), .o_audio_r(o_audio_r),
        .o_audio_b(o_audio_b), .o_audio_par_err(o_audio_par_err)
    );

    always #5 i_pixclk = ~i_pixclk;

    int cyc = 0;
    always @(posedge i_pixclk) cyc <= cyc + 1;

    typedef struct { logic [23:0] hdr; logic [223:0] sub; logic herr; logic [3:0] serr; } pkt_t;
    typedef struct { logic [19:0] cts; logic [19:0] n; } acr_t;
    typedef struct { logic [15:0] l; logic [15:0] r; logic b; logic par; } aud_t;

    pkt_t exp_pkt[int];
    acr_t exp_acr[int];
    aud_t exp_aud[int];
    bit   exp_sync[int];
    bit   partial = 1'b0;

    logic [23:0]  m_hdr = '0;
    logic [223:0] m_sub = '0;
    logic [19:0]  m_cts = '0, m_n = '0;

    int   pv_log[$];
    aud_t aud_log[$];
    logic last_herr = 1'b0;
    logic [3:0] last_serr = 4'h0;
    int   sync_cnt = 0, acr_cnt = 0;

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [335:0] act, input logic [335:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] bch(input logic [55:0] bits, input int n);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < n; i++)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ bits[i]) ? 8'hC1 : 8'h00);
        return c;
    endfunction

    task automatic drive(input logic data, input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2);
        @(posedge i_pixclk);
        #1;
        if (partial && (!data || !d0[3])) begin
            exp_sync[cyc + 1] = 1'b1;
            partial = 1'b0;
        end
        i_data = data;
        i_d0   = d0;
        i_d1   = d1;
        i_d2   = d2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h9, 4'h0, 4'h0);
    endtask

    // Encode one packet, drive n_slots of it, and record what the decoder must publish.
    task automatic send_packet(input logic [23:0] hdr, input logic [223:0] subs, input bit first,
                               input int n_slots, input int hflip, input int sflip_k,
                               input int sflip_slot);
        logic [31:0]  hb;
        logic [3:0]   ev[32];
        logic [3:0]   od[32];
        logic [7:0]   hc, pc;
        logic [55:0]  sb;
        logic [55:0]  srx[4];
        logic [223:0] subrx;
        logic [3:0]   serr;
        logic         herr;
        int           t31, idx;
        pkt_t         p;
        acr_t         a;
        aud_t         s_;
        hc = bch({32'h0, hdr}, 24);
        hb[23:0] = hdr;
        for (int i = 0; i < 8; i++) hb[24 + i] = hc[7 - i];
        for (int k = 0; k < 4; k++) begin
            sb = subs[56 * k +: 56];
            pc = bch(sb, 56);
            for (int s = 0; s < 28; s++) begin
                ev[s][k] = sb[2 * s];
                od[s][k] = sb[2 * s + 1];
            end
            for (int j = 0; j < 4; j++) begin
                ev[28 + j][k] = pc[7 - 2 * j];
                od[28 + j][k] = pc[6 - 2 * j];
            end
        end
        herr = 1'b0;
        serr = 4'h0;
        if (hflip >= 0) begin
            hb[hflip] = ~hb[hflip];
            herr = 1'b1;
        end
        if (sflip_k >= 0) begin
            ev[sflip_slot][sflip_k] = ~ev[sflip_slot][sflip_k];
            serr[sflip_k] = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 28; s++) begin
                srx[k][2 * s]     = ev[s][k];
                srx[k][2 * s + 1] = od[s][k];
            end
            subrx[56 * k +: 56] = srx[k];
        end
        t31 = 0;
        for (int s = 0; s < n_slots; s++) begin
            drive(1'b1, {(first && s == 0) ? 1'b0 : 1'b1, hb[s], 2'b01}, ev[s], od[s]);
            if (s == 31) t31 = cyc;
        end
        partial = (n_slots != 32);
        if (!partial) begin
            p.hdr = hb[23:0];
            p.sub = subrx;
            p.herr = herr;
            p.serr = serr;
            exp_pkt[t31 + 1] = p;
            if (hb[7:0] == 8'h01 && !herr && !serr[0]) begin
                a.cts = {srx[0][11:8], srx[0][23:16], srx[0][31:24]};
                a.n   = {srx[0][35:32], srx[0][47:40], srx[0][55:48]};
                exp_acr[t31 + 1] = a;
            end
            if (hb[7:0] == 8'h02 && !herr) begin
                idx = 0;
                for (int k = 0; k < 4; k++) begin
                    if (hb[8 + k] && !serr[k]) begin
                        s_.l   = srx[k][23:8];
                        s_.r   = srx[k][47:32];
                        s_.b   = hb[20 + k];
                        s_.par = (srx[k][51] != ^{srx[k][23:0], srx[k][50:48]}) |
                                 (srx[k][55] != ^{srx[k][47:24], srx[k][54:52]});
                        exp_aud[t31 + 2 + idx] = s_;
                        idx++;
                    end
                end
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge i_pixclk);
        #1;
        i_reset_n = 1'b0;
        i_data    = 1'b0;
        partial   = 1'b0;
        repeat (3) @(posedge i_pixclk);
        #1;
        i_reset_n = 1'b1;
    endtask

    always @(negedge i_pixclk) begin
        if (!i_reset_n) begin
            check("reset_outputs",
                  {o_pkt_valid, o_pkt_hdr, o_pkt_sub, o_hdr_err, o_sub_err, o_sync_err,
                   o_acr_valid, o_cts, o_n, o_audio_valid, o_audio_l, o_audio_r,
                   o_audio_b, o_audio_par_err}, '0);
            m_hdr = '0;
            m_sub = '0;
            m_cts = '0;
            m_n   = '0;
        end else begin
            check("pkt_valid", o_pkt_valid, exp_pkt.exists(cyc));
            if (exp_pkt.exists(cyc)) begin
                m_hdr = exp_pkt[cyc].hdr;
                m_sub = exp_pkt[cyc].sub;
                check("hdr_err", o_hdr_err, exp_pkt[cyc].herr);
                check("sub_err", o_sub_err, exp_pkt[cyc].serr);
            end
            check("pkt_hdr", o_pkt_hdr, m_hdr);
            check("pkt_sub", o_pkt_sub, m_sub);
            check("acr_valid", o_acr_valid, exp_acr.exists(cyc));
            if (exp_acr.exists(cyc)) begin
                m_cts = exp_acr[cyc].cts;
                m_n   = exp_acr[cyc].n;
            end
            check("cts", o_cts, m_cts);
            check("n", o_n, m_n);
            check("sync_err", o_sync_err, exp_sync.exists(cyc));
            check("audio_valid", o_audio_valid, exp_aud.exists(cyc));
            if (exp_aud.exists(cyc))
                check("audio_sample", {o_audio_l, o_audio_r, o_audio_b, o_audio_par_err},
                      {exp_aud[cyc].l, exp_aud[cyc].r, exp_aud[cyc].b, exp_aud[cyc].par});
            if (o_pkt_valid) begin
                pv_log.push_back(cyc);
                last_herr = o_hdr_err;
                last_serr = o_sub_err;
            end
            if (o_audio_valid)
                aud_log.push_back('{o_audio_l, o_audio_r, o_audio_b, o_audio_par_err});
            if (o_sync_err) sync_cnt++;
            if (o_acr_valid) acr_cnt++;
        end
    end

    localparam logic [55:0]  ACR_SUB   = 56'h00180078690000;
    localparam logic [223:0] ACR_SUBS  = {ACR_SUB, ACR_SUB, ACR_SUB, ACR_SUB};
    localparam logic [23:0]  AUD_HDR   = 24'h100302;
    localparam logic [223:0] AUD_SUBS  = {56'h0, 56'h0, 56'h88800000000100, 56'h08ABCD00123400};

    int p0, s0, n0;

    initial begin
        repeat (3) @(posedge i_pixclk);
        #1;
        i_reset_n = 1'b1;
        idle(2);

        send_packet(24'h000001, ACR_SUBS, 1'b1, 32, -1, -1, -1);
        idle(4);
        check("acr_cts_literal", o_cts, 20'h06978);
        check("acr_n_literal", o_n, 20'h01800);
        check("acr_count", acr_cnt, 1);

        send_packet(AUD_HDR, AUD_SUBS, 1'b1, 32, -1, -1, -1);
        idle(8);
        check("audio_count", aud_log.size(), 2);
        if (aud_log.size() >= 2) begin
            check("audio0_literal", {aud_log[0].l, aud_log[0].r, aud_log[0].b, aud_log[0].par},
                  {16'h1234, 16'hABCD, 1'b1, 1'b0});
            check("audio1_literal", {aud_log[1].l, aud_log[1].r, aud_log[1].b, aud_log[1].par},
                  {16'h0001, 16'h8000, 1'b0, 1'b0});
        end

        send_packet(AUD_HDR, AUD_SUBS, 1'b1, 32, -1, 1, 5);
        idle(8);
        check("sub1_flip_err_literal", last_serr, 4'b0010);
        check("sub1_flip_audio_count", aud_log.size(), 3);

        send_packet(AUD_HDR, AUD_SUBS, 1'b1, 32, 26, -1, -1);
        idle(8);
        check("hdr_flip_err_literal", last_herr, 1'b1);
        check("hdr_flip_audio_count", aud_log.size(), 3);

        send_packet(24'h000001, ACR_SUBS, 1'b1, 32, -1, -1, -1);
        send_packet(AUD_HDR, AUD_SUBS, 1'b0, 32, -1, -1, -1);
        idle(8);
        n0 = pv_log.size();
        if (n0 >= 2) check("b2b_spacing", pv_log[n0 - 1] - pv_log[n0 - 2], 32);
        check("b2b_audio_count", aud_log.size(), 5);

        p0 = pv_log.size();
        s0 = sync_cnt;
        send_packet(AUD_HDR, AUD_SUBS, 1'b1, 17, -1, -1, -1);
        idle(3);
        check("drop_sync_count", sync_cnt, s0 + 1);
        check("drop_no_pkt", pv_log.size(), p0);
        send_packet(AUD_HDR, AUD_SUBS, 1'b1, 32, -1, -1, -1);
        idle(8);
        check("after_drop_audio_count", aud_log.size(), 7);

        s0 = sync_cnt;
        send_packet(AUD_HDR, AUD_SUBS, 1'b1, 5, -1, -1, -1);
        send_packet(24'h000001, ACR_SUBS, 1'b1, 32, -1, -1, -1);
        idle(4);
        check("restart_sync_count", sync_cnt, s0 + 1);

        p0 = pv_log.size();
        s0 = sync_cnt;
        send_packet(24'h000001, ACR_SUBS, 1'b1, 10, -1, -1, -1);
        pulse_reset();
        idle(3);
        check("reset_no_pkt", pv_log.size(), p0);
        check("reset_no_sync", sync_cnt, s0);
        check("reset_cts_cleared", o_cts, 20'h0);
        send_packet(24'h000001, ACR_SUBS, 1'b1, 32, -1, -1, -1);
        idle(4);
        check("post_reset_n_literal", o_n, 20'h01800);
        check("post_reset_cts_literal", o_cts, 20'h06978);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdmi_data_decoder.md
# hdmi_data_decoder

Receive-side HDMI data-island packet decoder. It sits after TERC4 decoding, in the i_pixclk domain of the capture path, and consumes the per-pixel 4-bit channel nibbles of a data island. It reassembles 32-cycle packets, checks the BCH(32,24) header ECC and the BCH(64,56) subpacket ECC, and publishes each packet. It also extracts Audio Clock Regeneration (CTS/N) values and 16-bit L/R audio samples for the audio sink.

## Interface
- No parameters.
- i_pixclk  in  1  pixel clock; all logic on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_data  in  1  high while the current pixel is a data-island period.
- i_d0  in  4  ch0 nibble: [0] hsync, [1] vsync, [2] header bit, [3] 0 only on the first island cycle.
- i_d1  in  4  ch1 nibble: bit k = even bit of subpacket k.
- i_d2  in  4  ch2 nibble: bit k = odd bit of subpacket k.
- o_pkt_valid  out  1  one-cycle strobe when a packet is complete.
- o_pkt_hdr  out  24  HB2:HB1:HB0; HB0 = [7:0] = packet type.
- o_pkt_sub  out  224  subpackets 3..0, 56 bits each; subpacket k at [56k+55:56k].
- o_hdr_err  out  1  header ECC mismatch; qualified by o_pkt_valid.
- o_sub_err  out  4  per-subpacket ECC mismatch; qualified by o_pkt_valid.
- o_sync_err  out  1  one-cycle strobe when a partial packet is discarded.
- o_acr_valid  out  1  one-cycle strobe when a new CTS/N pair is available.
- o_cts  out  20  CTS from the last good ACR packet.
- o_n  out  20  N from the last good ACR packet.
- o_audio_valid  out  1  one-cycle strobe per audio sample.
- o_audio_l  out  16  left sample.
- o_audio_r  out  16  right sample.
- o_audio_b  out  1  sample starts an IEC60958 block.
- o_audio_par_err  out  1  sample parity mismatch (sample is still delivered).

## Operation
- States: IDLE, RECV. A 5-bit offset counter selects the bit slot within the packet.
- IDLE → RECV with offset 0 when i_data=1 and i_d0[3]=0; that cycle is captured as bit slot 0.
- In RECV, each cycle with i_data=1 captures one slot and increments offset.
- Offset wraps 31→0 and stays in RECV, so back-to-back packets in the same island are decoded.
- i_data=0 in RECV returns to IDLE. If offset≠0, pulse o_sync_err and output nothing.
- i_d0[3]=0 while in RECV with offset≠0: pulse o_sync_err, discard the partial packet, restart at offset 0 with the current cycle as slot 0.
- Header: slots 0–23 give header bits 0–23 (LSB first) from i_d0[2]. Slots 24–31 give parity bits 0–7.
- Subpacket k: slots 0–27 give bit pairs {2s+1, 2s} = {i_d2[k], i_d1[k]}. Slots 28–31 give parity pairs {i_d1[k] = p[2j], i_d2[k] = p[2j+1]}.
- ECC uses the generator 1+x^6+x^7, with an 8-bit LFSR per stream, cleared at slot 0.
  - Data bit b updates the LFSR as c ← (c<<1) ^ ((c[7]^b) ? 8'hC1 : 0).
  - Subpackets feed the even bit, then the odd bit, per slot.
  - Expected parity is emitted MSB-first: p0 = c[7], p1 = c[6], …, with the LFSR shifted left without feedback.
  - Any mismatched parity bit sets the stream's error flag.
- Packet type 8'h01 (ACR) with no header error and no sub0 error:
  - o_cts = {sub0[11:8], sub0[23:16], sub0[31:24]}.
  - o_n = {sub0[35:32], sub0[47:40], sub0[55:48]}.
  - Pulse o_acr_valid.
- Packet type 8'h02 (audio sample) with no header error: subpacket k is a sample when hdr[8+k]=1 and o_sub_err[k]=0.
  - L = sub[23:8], R = sub[47:32], B = hdr[20+k].
  - par_err = (sub[51] ≠ ^{sub[23:0], sub[50:48]}) | (sub[55] ≠ ^{sub[47:24], sub[54:52]}).
- Valid samples are queued in a 4-entry buffer and emitted one per cycle in ascending k order.
- All other packet types only produce o_pkt_valid.

## Timing
- Reset value of every output is 0, including o_cts and o_n. Internal state returns to IDLE.
- Reset asserted mid-packet discards the packet without a strobe.
- o_pkt_valid, o_hdr_err, o_sub_err, o_pkt_hdr and o_pkt_sub are registered. They appear in the cycle after slot 31 is captured.
- o_pkt_hdr and o_pkt_sub hold their values until the next o_pkt_valid.
- o_acr_valid is coincident with o_pkt_valid. o_cts and o_n update in the same cycle and hold otherwise.
- The first o_audio_valid comes one cycle after o_pkt_valid. Samples are emitted on consecutive cycles, up to 4.
- A new packet cannot complete sooner than 32 cycles later, so the sample buffer never overflows.
- o_sync_err is asserted in the cycle after the offending input cycle.

## Test plan
- ACR packet with N=6144 and CTS=27000, valid BCH: one o_pkt_valid, o_hdr_err=0, o_acr_valid=1, o_n=20'h01800, o_cts=20'h06978.
- Audio packet with hdr 24'h100302, sub0 L=16'h1234 R=16'hABCD, sub1 L=16'h0001 R=16'h8000, correct parity and BCH: two o_audio_valid on cycles +1 and +2. Expected samples: (1234, ABCD, b=1) then (0001, 8000, b=0), par_err=0.
- Same audio packet with one flipped bit in sub1 data: o_sub_err=4'b0010, only the sub0 sample is emitted. A flipped header parity bit gives o_hdr_err=1 and no samples.
- Two back-to-back packets in one 64-cycle island (ACR then audio): two o_pkt_valid strobes exactly 32 cycles apart, both decoded correctly.
- i_data drops at offset 17: o_sync_err pulse, no o_pkt_valid. A new island right after decodes normally.
- i_reset_n low at offset 10: all outputs 0, no strobes. After release, a full packet decodes normally.
